// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle RV32I/RV64I integer ALU with valid/ready
// handshakes on both sides. Shifts run on an iterative shifter that moves
// SHIFT_STEP bit positions per cycle.
// Optional feature macro: ALU_SEQ_MUL_EN adds a funct7_0 port and an
// iterative shift-add MUL (low XLEN bits of the product).
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] aluin1,
  input  logic [XLEN-1:0] aluin2,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
`ifdef ALU_SEQ_MUL_EN
  input  logic            funct7_0,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluout
);

  localparam int SW = $clog2(XLEN);
  // One extra bit so the counter can hold XLEN for the multiply loop.
  localparam int CW = SW + 1;
  localparam logic [CW-1:0]   STEP_C   = CW'(SHIFT_STEP);
  localparam logic [CW-1:0]   ONE_CW   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef ALU_SEQ_MUL_EN
    , ST_MUL = 2'd2
`endif
  } state_t;

  state_t          state_r, state_n_s;
  logic [XLEN-1:0] work_r;
  logic [XLEN-1:0] aluout_r;
  logic [CW-1:0]   rem_r;
  logic            shl_r;
  logic            sra_r;
  logic            out_valid_r;

  logic            accept_s;
  logic            is_shift_s;
  logic            start_shift_s;
  logic            start_mul_s;
  logic            last_shift_s;
  logic [SW-1:0]   shamt_s;
  logic [CW-1:0]   step_s;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] res_s;
  logic [XLEN-1:0] step_res_s;
  logic            wr_s;
  logic [XLEN-1:0] wr_val_s;

`ifdef ALU_SEQ_MUL_EN
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] acc_n_s;
  logic            last_mul_s;
  logic            mul_sel_s;

  // funct7_0 marks an M-extension op; only funct3=000 (MUL) is iterative.
  assign mul_sel_s   = funct7_0;
  assign start_mul_s = accept_s && funct7_0 && (funct3 == 3'b000);
`else
  assign start_mul_s = 1'b0;
`endif

  assign shamt_s   = aluin2[SW-1:0];
  assign in_ready  = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign aluout    = aluout_r;

  // Decode the request and compute the single-cycle result.
  always_comb begin
    alu_s = ZERO_X;
    case (funct3)
      3'b000:         alu_s = funct7_5 ? (aluin1 - aluin2) : (aluin1 + aluin2);
      3'b001, 3'b101: alu_s = aluin1;  // zero shift amount passes operand through
      3'b010:         alu_s = ($signed(aluin1) < $signed(aluin2)) ? ONE_X : ZERO_X;
      3'b011:         alu_s = (aluin1 < aluin2) ? ONE_X : ZERO_X;
      3'b100:         alu_s = aluin1 ^ aluin2;
      3'b110:         alu_s = aluin1 | aluin2;
      3'b111:         alu_s = aluin1 & aluin2;
      default:        alu_s = ZERO_X;
    endcase
`ifdef ALU_SEQ_MUL_EN
    is_shift_s = !mul_sel_s && ((funct3 == 3'b001) || (funct3 == 3'b101));
    res_s      = mul_sel_s ? ZERO_X : alu_s;
`else
    is_shift_s = (funct3 == 3'b001) || (funct3 == 3'b101);
    res_s      = alu_s;
`endif
    start_shift_s = accept_s && is_shift_s && (shamt_s != {SW{1'b0}});
  end

  // One iteration of the shifter: move by min(SHIFT_STEP, remaining).
  always_comb begin
    last_shift_s = (rem_r <= STEP_C);
    step_s       = last_shift_s ? rem_r : STEP_C;
    if (shl_r) begin
      step_res_s = work_r << step_s;
    end else if (sra_r) begin
      step_res_s = $signed(work_r) >>> step_s;
    end else begin
      step_res_s = work_r >> step_s;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add iteration, consuming the low multiplier bit.
  always_comb begin
    acc_n_s    = mplier_r[0] ? (acc_r + work_r) : acc_r;
    last_mul_s = (rem_r == ONE_CW);
  end
`endif

  // FSM next state and result-write decision.
  always_comb begin
    state_n_s = state_r;
    wr_s      = 1'b0;
    wr_val_s  = res_s;
    case (state_r)
      ST_IDLE: begin
        if (start_shift_s) begin
          state_n_s = ST_SHIFT;
`ifdef ALU_SEQ_MUL_EN
        end else if (start_mul_s) begin
          state_n_s = ST_MUL;
`endif
        end else if (accept_s) begin
          wr_s     = 1'b1;
          wr_val_s = res_s;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift_s) begin
          state_n_s = ST_IDLE;
          wr_s      = 1'b1;
          wr_val_s  = step_res_s;
        end else begin
          state_n_s = ST_SHIFT;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (last_mul_s) begin
          state_n_s = ST_IDLE;
          wr_s      = 1'b1;
          wr_val_s  = acc_n_s;
        end else begin
          state_n_s = ST_MUL;
        end
      end
`endif
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath: operand latching, iteration registers and the output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      aluout_r    <= ZERO_X;
      work_r      <= ZERO_X;
      rem_r       <= {CW{1'b0}};
      shl_r       <= 1'b0;
      sra_r       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplier_r    <= ZERO_X;
      acc_r       <= ZERO_X;
`endif
    end else begin
      if (wr_s) begin
        aluout_r    <= wr_val_s;
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (start_shift_s) begin
        work_r <= aluin1;
        rem_r  <= {1'b0, shamt_s};
        shl_r  <= (funct3 == 3'b001);
        sra_r  <= funct7_5;
`ifdef ALU_SEQ_MUL_EN
      end else if (start_mul_s) begin
        work_r   <= aluin1;
        mplier_r <= aluin2;
        acc_r    <= ZERO_X;
        rem_r    <= CW'(XLEN);
      end else if (state_r == ST_MUL) begin
        work_r   <= work_r << 1'b1;
        mplier_r <= mplier_r >> 1'b1;
        acc_r    <= acc_n_s;
        rem_r    <= rem_r - ONE_CW;
`endif
      end else if (state_r == ST_SHIFT) begin
        work_r <= step_res_s;
        rem_r  <= rem_r - step_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard testbench for alu_seq: a driver issues requests and pushes the
// expected result and presentation cycle; a monitor pops and compares when
// the DUT presents output. A second instance with SHIFT_STEP=4 checks the
// multi-bit shift latency.
module tb_alu_seq;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] aluin1 = 32'd0;
  logic [31:0] aluin2 = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] aluout;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [31:0] aluin1_4 = 32'd0;
  logic [31:0] aluin2_4 = 32'd0;
  logic [2:0]  funct3_4 = 3'd0;
  logic        funct7_5_4 = 1'b0;
  logic        out_valid4;
  logic [31:0] aluout4;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          rnd_ready = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] exp_val_q[$];
  int          exp_cyc_q[$];

  alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluin1(aluin1), .aluin2(aluin2), .funct3(funct3), .funct7_5(funct7_5),
    .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout)
  );

  alu_seq #(.XLEN(XLEN), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .aluin1(aluin1_4), .aluin2(aluin2_4), .funct3(funct3_4), .funct7_5(funct7_5_4),
    .out_valid(out_valid4), .out_ready(1'b1), .aluout(aluout4)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected presentation.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the architectural result of each op.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7);
    int unsigned sh;
    logic [31:0] fill;
    sh = b[4:0];
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (f3)
      3'd0: return f7 ? (a - b) : (a + b);
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? ((a >> sh) | fill) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input logic [2:0] f3, input int step);
    int sh;
    sh = int'(b[4:0]);
    if (f3 == 3'd1 || f3 == 3'd5) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_val_q.size() == 0) begin
        check("unexpected_output", {32'd0, aluout}, 64'hDEAD_0000_0000_0000);
      end else begin
        if (!prev_pend) check("latency", 64'(cyc), 64'(exp_cyc_q[0]));
        check("aluout", {32'd0, aluout}, {32'd0, exp_val_q[0]});
        if (out_ready) begin
          void'(exp_val_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
    prev_pend <= out_valid && !out_ready;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic f7);
    int tries = 0;
    bit done = 1'b0;
    bit ok = 1'b0;
    in_valid = 1'b1; aluin1 = a; aluin2 = b; funct3 = f3; funct7_5 = f7;
    while (!done) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        done = 1'b1; ok = 1'b1;
      end else if (tries > 200) begin
        check("issue_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end else begin
        tries++;
        @(posedge clk); #1;
      end
    end
    if (ok) begin
      exp_val_q.push_back(ref_alu(a, b, f3, f7));
      exp_cyc_q.push_back(cyc + ref_lat(b, f3, STEP));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_val_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_val_q.size()), 64'd0);
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic f7);
    int c0;
    int n = 0;
    bit seen = 1'b0;
    in_valid4 = 1'b1; aluin1_4 = a; aluin2_4 = b; funct3_4 = f3; funct7_5_4 = f7;
    #1;
    check("dut4_in_ready", {63'd0, in_ready4}, 64'd1);
    c0 = cyc;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
      else n++;
    end
    check("dut4_latency", 64'(cyc - c0), 64'(ref_lat(b, f3, 4)));
    check("dut4_aluout", {32'd0, aluout4}, {32'd0, ref_alu(a, b, f3, f7)});
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int c0;
    logic [2:0] f3;
    // Reset behaviour.
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_during_rst", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_aluout", {32'd0, aluout}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Basic single-cycle ops.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0);
    check("in_ready_after_add", {63'd0, in_ready}, 64'd1);
    issue(32'd5, 32'd7, 3'd0, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0);
    wait_drain();

    // Long arithmetic shift; block must be busy meanwhile.
    issue(32'h8000_0000, 32'd31, 3'd5, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("in_ready_in_shift", {63'd0, in_ready}, 64'd0);
    wait_drain();
    issue(32'h1234_5678, 32'd0, 3'd1, 1'b0);
    issue(32'h8765_4321, 32'd7, 3'd5, 1'b0);
    issue(32'h0000_00F1, 32'd12, 3'd1, 1'b0);
    wait_drain();

    // Shift-step instance latency.
    run4(32'h8000_0000, 32'd31, 3'd5, 1'b1);
    run4(32'h0000_0003, 32'd5, 3'd1, 1'b0);
    run4(32'hF000_0000, 32'd4, 3'd5, 1'b0);

    // Backpressure: result held, no new accept until released.
    out_ready = 1'b0;
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_aluout", {32'd0, aluout}, 64'hFF00_FF00);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(32'd100, 32'd23, 3'd0, 1'b0);
    wait_drain();

    // Back-to-back stream.
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue($urandom, $urandom, 3'd7, 1'b0);
    check("stream_cycles", 64'(cyc - c0), 64'd8);
    wait_drain();

    // Reset in the middle of a shift.
    issue(32'hDEAD_BEEF, 32'd20, 3'd1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_val_q.delete();
    exp_cyc_q.delete();
    #1;
    check("in_ready_rst_mid", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_aluout", {32'd0, aluout}, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    issue(32'h0000_000F, 32'h0000_00F0, 3'd6, 1'b0);
    wait_drain();

    // Randomized traffic with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end else begin
        f3 = 3'($urandom_range(0, 7));
        issue($urandom, $urandom, f3, 1'($urandom_range(0, 1)));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
